cla_adder_pipe: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's fixed-width registered CLA adder.
- Operand width and CLA group size are parameters. Each pipeline stage resolves one CLA group.
- Adds a valid/ready handshake with back-pressure, a subtract mode, and status flags (carry, signed overflow, zero).
- Sits between operand sources and the datapath result bus.

---
 rtl/cla_pkg.sv | 35 +++
 rtl/cla_group.sv | 36 +++
 rtl/cla_adder_pipe.sv | 120 ++++++++++++
 tb/tb_cla_adder_pipe.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
package cla_pkg;

  // Widest CLA group the lookahead helper can expand.
  localparam int MAX_BLOCK = 32;

  // Number of pipeline stages: one per CLA group.
  function automatic int num_groups(input int width, input int block);
    return (block < 1) ? 1 : width / block;
  endfunction

  // Carry into bit j of a group as a flat sum of products:
  //   c[j] = cin&p[0..j-1] | g[0]&p[1..j-1] | ... | g[j-1]
  // Every term is taken directly from p/g/cin, so no carry ripples.
  function automatic logic group_carry(input logic [MAX_BLOCK-1:0] p,
                                       input logic [MAX_BLOCK-1:0] g,
                                       input logic                 cin,
                                       input int                   j);
    logic c;
    logic t;
    c = cin;
    for (int k = 0; k < MAX_BLOCK; k++)
      if (k < j) c = c & p[k];
    for (int i = 0; i < MAX_BLOCK; i++) begin
      if (i < j) begin
        t = g[i];
        for (int k = 0; k < MAX_BLOCK; k++)
          if (k > i && k < j) t = t & p[k];
        c = c | t;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_group.sv
// One CLA group: full lookahead over BLOCK bits, plus group P/G.
module cla_group import cla_pkg::*; #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             P,
  output logic             G
);

  logic [BLOCK-1:0]     p, g;
  logic [MAX_BLOCK-1:0] pw, gw;
  logic [BLOCK:0]       c;

  assign p = a ^ b;
  assign g = a & b;

  // Expand every carry of the group directly from p, g and cin.
  always_comb begin
    pw = '0;
    gw = '0;
    pw[BLOCK-1:0] = p;
    gw[BLOCK-1:0] = g;
    for (int j = 0; j <= BLOCK; j++)
      c[j] = group_carry(pw, gw, cin, j);
    G = group_carry(pw, gw, 1'b0, BLOCK);
  end

  assign sum  = p ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
  assign P    = &p;

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined CLA adder/subtractor: one CLA group resolved per stage,
// whole-pipe valid/ready stall, registered carry/overflow/zero flags.
module cla_adder_pipe import cla_pkg::*; #(
  parameter int WIDTH = 12,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CE,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = num_groups(WIDTH, BLOCK);

  if (BLOCK < 1 || BLOCK > MAX_BLOCK || (WIDTH % BLOCK) != 0) begin : g_param_err
    $error("cla_adder_pipe: WIDTH must be a multiple of BLOCK, 1 <= BLOCK <= MAX_BLOCK");
  end

  // Per-stage state: sum bits resolved so far, operands still to be
  // consumed (Beff already inverted for subtract), group carry.
  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
  } stage_t;

  logic             adv;
  logic [NG:1]      vld_pipe;
  logic [WIDTH-1:0] beff;
  logic             ceff;
  logic             ovf_q, zero_q;

  // The pipe moves as one unit; a full, unconsumed output stalls everything.
  assign adv      = CE & (~out_valid | out_ready);
  assign in_ready = adv;

  // Subtract as A + ~B + 1; Cin is ignored in that mode.
  assign beff = sub ? ~B : B;
  assign ceff = sub | Cin;

  for (genvar i = 0; i < NG; i++) begin : g_stage
    stage_t           src, nxt, q;
    logic [BLOCK-1:0] gsum;
    logic             gcout, gp, gg;
    logic             unused_pg;

    if (i == 0) begin : g_first
      assign src = '{s: '0, a: A, b: beff, c: ceff};
    end else begin : g_next
      assign src = g_stage[i-1].q;
    end

    cla_group #(.BLOCK(BLOCK)) u_grp (
      .a    (src.a[i*BLOCK +: BLOCK]),
      .b    (src.b[i*BLOCK +: BLOCK]),
      .cin  (src.c),
      .sum  (gsum),
      .cout (gcout),
      .P    (gp),
      .G    (gg)
    );

    // Splice this group's sum in and hand its carry to the next stage.
    always_comb begin
      nxt = src;
      nxt.s[i*BLOCK +: BLOCK] = gsum;
      nxt.c = gcout;
    end

    // Stage register, held while the pipe is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= '0;
      else if (adv) q <= nxt;
    end

    // Group P/G are not needed here; the final stage's operands neither.
    assign unused_pg = &{1'b0, gp, gg, q.a, q.b};
  end

  // Valid shift register, advancing with the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int i = 2; i <= NG; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Flags are computed from the final stage's inputs and registered with S.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv) begin
      ovf_q  <= (g_stage[NG-1].nxt.a[WIDTH-1] == g_stage[NG-1].nxt.b[WIDTH-1]) &
                (g_stage[NG-1].nxt.s[WIDTH-1] != g_stage[NG-1].nxt.a[WIDTH-1]);
      zero_q <= ~|g_stage[NG-1].nxt.s;
    end
  end

  assign out_valid = vld_pipe[NG];
  assign S         = g_stage[NG-1].q.s;
  assign Cout      = g_stage[NG-1].q.c;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe (WIDTH=12, BLOCK=4, three stages).
module tb_cla_adder_pipe;

  logic        clk, rst_n, CE, in_valid, in_ready, Cin, sub;
  logic        out_valid, out_ready, Cout, ovf, zero;
  logic [11:0] A, B, S;

  int n_chk  = 0;
  int n_fail = 0;

  cla_adder_pipe #(.WIDTH(12), .BLOCK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .CE        (CE),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [11:0] a, input logic [11:0] b,
                       input logic c, input logic s);
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = c;
    sub      = s;
  endtask

  task automatic expect_out(input string tag, input logic [11:0] s, input logic c,
                            input logic o, input logic z);
    chk({tag, ".vld"},  32'(out_valid), 32'd1);
    chk({tag, ".S"},    32'(S),         32'(s));
    chk({tag, ".Cout"}, 32'(Cout),      32'(c));
    chk({tag, ".ovf"},  32'(ovf),       32'(o));
    chk({tag, ".zero"}, 32'(zero),      32'(z));
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, ".vld"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; CE = 1'b1; out_ready = 1'b1;
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    tick; tick;
    #2 rst_n = 1'b1;
    #1;
    chk("rst.vld",  32'(out_valid), 32'd0);
    chk("rst.S",    32'(S),         32'd0);
    chk("rst.Cout", 32'(Cout),      32'd0);
    chk("rst.ovf",  32'(ovf),       32'd0);
    chk("rst.zero", 32'(zero),      32'd0);
    chk("rst.rdy",  32'(in_ready),  32'd1);

    // 1: wrap to zero, three-stage latency
    drive(1'b1, 12'hFFF, 12'h001, 1'b0, 1'b0);
    tick; expect_idle("t1.e1");
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    tick; expect_idle("t1.e2");
    tick; expect_out("t1", 12'h000, 1'b1, 1'b0, 1'b1);
    tick; expect_idle("t1.drain");

    // 2: subtract with overflow, then with borrow
    drive(1'b1, 12'h800, 12'h001, 1'b0, 1'b1); tick;
    drive(1'b1, 12'h001, 12'h002, 1'b1, 1'b1); tick;
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    tick; expect_out("t2a", 12'h7FF, 1'b1, 1'b1, 1'b0);
    tick; expect_out("t2b", 12'hFFF, 1'b0, 1'b0, 1'b0);
    tick; expect_idle("t2.drain");

    // 3: back-to-back stream
    drive(1'b1, 12'h123, 12'h456, 1'b1, 1'b0); tick;
    drive(1'b1, 12'h7FF, 12'h001, 1'b0, 1'b0); tick;
    drive(1'b1, 12'hABC, 12'h544, 1'b0, 1'b0); tick;
    expect_out("t3a", 12'h57A, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    tick; expect_out("t3b", 12'h800, 1'b0, 1'b1, 1'b0);
    tick; expect_out("t3c", 12'h000, 1'b1, 1'b0, 1'b1);
    tick; expect_idle("t3.drain");

    // 4: back-pressure with three in flight
    out_ready = 1'b0;
    drive(1'b1, 12'h00F, 12'h001, 1'b0, 1'b0); tick;
    drive(1'b1, 12'h100, 12'h0FF, 1'b1, 1'b0); tick;
    drive(1'b1, 12'h005, 12'h007, 1'b0, 1'b1); tick;
    expect_out("t4.held0", 12'h010, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    #1 chk("t4.rdy", 32'(in_ready), 32'd0);
    tick; expect_out("t4.held1", 12'h010, 1'b0, 1'b0, 1'b0);
    tick; expect_out("t4.held2", 12'h010, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick; expect_out("t4b", 12'h200, 1'b0, 1'b0, 1'b0);
    tick; expect_out("t4c", 12'hFFE, 1'b0, 1'b0, 1'b0);
    tick; expect_idle("t4.drain");

    // 5: CE freeze mid-stream
    drive(1'b1, 12'h111, 12'h222, 1'b0, 1'b0); tick;
    drive(1'b1, 12'h0F0, 12'h00F, 1'b1, 1'b0); tick;
    drive(1'b1, 12'h800, 12'h800, 1'b0, 1'b1); tick;
    expect_out("t5a", 12'h333, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 12'h400, 12'h400, 1'b0, 1'b0);
    CE = 1'b0;
    #1 chk("t5.rdy", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick;
      expect_out("t5.frz", 12'h333, 1'b0, 1'b0, 1'b0);
      chk("t5.frz.rdy", 32'(in_ready), 32'd0);
    end
    CE = 1'b1;
    tick; expect_out("t5b", 12'h100, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    tick; expect_out("t5c", 12'h000, 1'b1, 1'b0, 1'b1);
    tick; expect_out("t5d", 12'h800, 1'b0, 1'b1, 1'b0);
    tick; expect_idle("t5.drain");

    // 6: asynchronous reset with transactions in flight
    out_ready = 1'b0;
    drive(1'b1, 12'hFFF, 12'h002, 1'b0, 1'b0); tick;
    drive(1'b1, 12'h7FF, 12'h7FF, 1'b0, 1'b0); tick;
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    tick; expect_out("t6.pre", 12'h001, 1'b1, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("t6.rst.vld",  32'(out_valid), 32'd0);
    chk("t6.rst.S",    32'(S),         32'd0);
    chk("t6.rst.Cout", 32'(Cout),      32'd0);
    chk("t6.rst.ovf",  32'(ovf),       32'd0);
    chk("t6.rst.zero", 32'(zero),      32'd0);
    tick;
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick; expect_idle("t6.stale");
    end
    drive(1'b1, 12'h234, 12'h111, 1'b0, 1'b0);
    tick; expect_idle("t6.e1");
    drive(1'b0, 12'h000, 12'h000, 1'b0, 1'b0);
    tick; expect_idle("t6.e2");
    tick; expect_out("t6", 12'h345, 1'b0, 1'b0, 1'b0);
    tick; expect_idle("t6.drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
